// File: rtl/exp_align_ctrl.sv
// exp_align_ctrl: two-stage exponent alignment controller for the Posit FMAU
// multiplier path. Stage 1 forms the per-lane signed maximum of the product
// exponents (and the accumulator exponent unless it is zero). Stage 2 turns
// that maximum into saturated right-shift amounts for each operand. Lanes are
// packed 4x5, 2x10 or 1x20 bits and never exchange carries or comparisons.
module exp_align_ctrl #(
  parameter int unsigned SAT_Q = 15,
  parameter int unsigned SAT_H = 31,
  parameter int unsigned SAT_W = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [1:0]  mode,
  input  logic [19:0] exp_E,
  input  logic [19:0] exp_F,
  input  logic [19:0] exp_acc,
  input  logic        acc_zero,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [1:0]  out_mode,
  output logic [19:0] max_exp,
  output logic [19:0] sh_E,
  output logic [19:0] sh_F,
  output logic [19:0] sh_acc
);

  localparam logic [4:0]  SAT_Q5  = 5'(SAT_Q);
  localparam logic [9:0]  SAT_H10 = 10'(SAT_H);
  localparam logic [19:0] SAT_W20 = 20'(SAT_W);

  // ---------------------------------------------------------------------------
  // Per-lane helpers. Max is a signed compare confined to the lane; the shift
  // difference is taken one bit wider than the lane so it can never wrap.
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] max5(input logic [4:0] e, input logic [4:0] f,
                                      input logic [4:0] a, input logic use_acc);
    logic [4:0] m;
    m = ($signed(e) > $signed(f)) ? e : f;
    m = (use_acc && ($signed(a) > $signed(m))) ? a : m;
    return m;
  endfunction

  function automatic logic [9:0] max10(input logic [9:0] e, input logic [9:0] f,
                                       input logic [9:0] a, input logic use_acc);
    logic [9:0] m;
    m = ($signed(e) > $signed(f)) ? e : f;
    m = (use_acc && ($signed(a) > $signed(m))) ? a : m;
    return m;
  endfunction

  function automatic logic [19:0] max20(input logic [19:0] e, input logic [19:0] f,
                                        input logic [19:0] a, input logic use_acc);
    logic [19:0] m;
    m = ($signed(e) > $signed(f)) ? e : f;
    m = (use_acc && ($signed(a) > $signed(m))) ? a : m;
    return m;
  endfunction

  function automatic logic [4:0] sh5(input logic [4:0] mx, input logic [4:0] x);
    logic [5:0] d;
    d = {mx[4], mx} - {x[4], x};
    return (d > {1'b0, SAT_Q5}) ? SAT_Q5 : d[4:0];
  endfunction

  function automatic logic [9:0] sh10(input logic [9:0] mx, input logic [9:0] x);
    logic [10:0] d;
    d = {mx[9], mx} - {x[9], x};
    return (d > {1'b0, SAT_H10}) ? SAT_H10 : d[9:0];
  endfunction

  function automatic logic [19:0] sh20(input logic [19:0] mx, input logic [19:0] x);
    logic [20:0] d;
    d = {mx[19], mx} - {x[19], x};
    return (d > {1'b0, SAT_W20}) ? SAT_W20 : d[19:0];
  endfunction

  // Packed per-lane maximum for the given lane format.
  function automatic logic [19:0] pack_max(input logic [1:0] md, input logic [19:0] e,
                                           input logic [19:0] f, input logic [19:0] a,
                                           input logic use_acc);
    logic [19:0] r;
    r = 20'd0;
    case (md)
      2'b00: begin
        for (int i = 0; i < 4; i++) begin
          r[i*5 +: 5] = max5(e[i*5 +: 5], f[i*5 +: 5], a[i*5 +: 5], use_acc);
        end
      end
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          r[i*10 +: 10] = max10(e[i*10 +: 10], f[i*10 +: 10], a[i*10 +: 10], use_acc);
        end
      end
      default: r = max20(e, f, a, use_acc);
    endcase
    return r;
  endfunction

  // Packed per-lane saturated shift amount (max - x).
  function automatic logic [19:0] pack_shift(input logic [1:0] md, input logic [19:0] mx,
                                             input logic [19:0] x);
    logic [19:0] r;
    r = 20'd0;
    case (md)
      2'b00: begin
        for (int i = 0; i < 4; i++) begin
          r[i*5 +: 5] = sh5(mx[i*5 +: 5], x[i*5 +: 5]);
        end
      end
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          r[i*10 +: 10] = sh10(mx[i*10 +: 10], x[i*10 +: 10]);
        end
      end
      default: r = sh20(mx, x);
    endcase
    return r;
  endfunction

  // Saturation value replicated into every lane of the given format.
  function automatic logic [19:0] sat_pack(input logic [1:0] md);
    logic [19:0] r;
    case (md)
      2'b00:   r = {4{SAT_Q5}};
      2'b01:   r = {2{SAT_H10}};
      default: r = SAT_W20;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic        v1;
  logic [19:0] e1;
  logic [19:0] f1;
  logic [19:0] a1;
  logic [19:0] m1;
  logic [1:0]  mode1;
  logic        az1;

  logic        adv2;
  logic        load1;
  logic        load2;
  logic [19:0] max_in;
  logic [19:0] she_nxt;
  logic [19:0] shf_nxt;
  logic [19:0] sha_nxt;

  // Handshake: a stage advances when empty or when the stage after it drains.
  always_comb begin
    adv2   = !out_vld || out_rdy;
    in_rdy = !v1 || adv2;
    load1  = in_vld && in_rdy;
    load2  = v1 && adv2;
  end

  // Datapath: stage-1 maximum from the inputs, stage-2 shifts from stage 1.
  always_comb begin
    max_in  = pack_max(mode, exp_E, exp_F, exp_acc, !acc_zero);
    she_nxt = pack_shift(mode1, m1, e1);
    shf_nxt = pack_shift(mode1, m1, f1);
    if (az1) begin
      sha_nxt = sat_pack(mode1);
    end else begin
      sha_nxt = pack_shift(mode1, m1, a1);
    end
  end

  // Stage 1: capture operands, maximum, mode and acc_zero on input accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      e1    <= 20'd0;
      f1    <= 20'd0;
      a1    <= 20'd0;
      m1    <= 20'd0;
      mode1 <= 2'b00;
      az1   <= 1'b0;
    end else begin
      if (in_rdy) begin
        v1 <= in_vld;
      end
      if (load1) begin
        e1    <= exp_E;
        f1    <= exp_F;
        a1    <= exp_acc;
        m1    <= max_in;
        mode1 <= mode;
        az1   <= acc_zero;
      end
    end
  end

  // Stage 2: registered outputs, loaded on stage-1 to stage-2 transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_mode <= 2'b00;
      max_exp  <= 20'd0;
      sh_E     <= 20'd0;
      sh_F     <= 20'd0;
      sh_acc   <= 20'd0;
    end else begin
      if (adv2) begin
        out_vld <= v1;
      end
      if (load2) begin
        out_mode <= mode1;
        max_exp  <= m1;
        sh_E     <= she_nxt;
        sh_F     <= shf_nxt;
        sh_acc   <= sha_nxt;
      end
    end
  end

endmodule

// File: tb/tb_exp_align_ctrl.sv
// Directed self-checking bench for exp_align_ctrl.
module tb_exp_align_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [1:0]  mode;
  logic [19:0] exp_E;
  logic [19:0] exp_F;
  logic [19:0] exp_acc;
  logic        acc_zero;
  logic        out_vld;
  logic        out_rdy;
  logic [1:0]  out_mode;
  logic [19:0] max_exp;
  logic [19:0] sh_E;
  logic [19:0] sh_F;
  logic [19:0] sh_acc;

  int checks;
  int errors;

  exp_align_ctrl #(.SAT_Q(15), .SAT_H(31), .SAT_W(63)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .mode(mode),
    .exp_E(exp_E), .exp_F(exp_F), .exp_acc(exp_acc), .acc_zero(acc_zero),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_mode(out_mode), .max_exp(max_exp),
    .sh_E(sh_E), .sh_F(sh_F), .sh_acc(sh_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one transaction into an empty pipeline and returns what it saw.
  task automatic run_txn(input logic [1:0] md, input logic [19:0] e, input logic [19:0] f,
                         input logic [19:0] a, input logic az,
                         output logic rdy_seen, output logic vld_early, output logic vld,
                         output logic [1:0] om, output logic [19:0] mx,
                         output logic [19:0] se, output logic [19:0] sf, output logic [19:0] sa);
    @(posedge clk); #1;
    in_vld = 1'b1; mode = md; exp_E = e; exp_F = f; exp_acc = a; acc_zero = az;
    out_rdy = 1'b1;
    @(negedge clk); rdy_seen = in_rdy;
    @(posedge clk); #1;
    in_vld = 1'b0;
    @(negedge clk); vld_early = out_vld;
    @(negedge clk);
    vld = out_vld; om = out_mode; mx = max_exp; se = sh_E; sf = sh_F; sa = sh_acc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_vld = 1'b0; mode = 2'b00; exp_E = 20'd0; exp_F = 20'd0;
    exp_acc = 20'd0; acc_zero = 1'b0; out_rdy = 1'b0;
    #12;
    checks++;
    if (out_vld !== 1'b0 || out_mode !== 2'b00 || max_exp !== 20'd0 || sh_E !== 20'd0 ||
        sh_F !== 20'd0 || sh_acc !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b mode=%b max=%h shE=%h shF=%h shA=%h, required all 0",
               out_vld, out_mode, max_exp, sh_E, sh_F, sh_acc);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_rdy=%b out_vld=%b, required 1 0", in_rdy, out_vld);
    end
  endtask

  task automatic test_mode00_stream;
    logic r, ve, v; logic [1:0] om; logic [19:0] mx, se, sf, sa;
    run_txn(2'b00, 20'h00003, 20'h0001E, 20'h00001, 1'b0, r, ve, v, om, mx, se, sf, sa);
    checks++;
    if (r !== 1'b1 || ve !== 1'b0 || v !== 1'b1) begin
      errors++;
      $display("FAIL m00_latency: rdy=%b vld_after1=%b vld_after2=%b, required 1 0 1", r, ve, v);
    end
    checks++;
    if (mx !== 20'h00003) begin
      errors++; $display("FAIL m00_max: got %h, required 00003", mx);
    end
    checks++;
    if (se !== 20'h00000 || sf !== 20'h00005 || sa !== 20'h00002) begin
      errors++;
      $display("FAIL m00_shifts: got %h %h %h, required 00000 00005 00002", se, sf, sa);
    end
  endtask

  task automatic test_mode00_saturation;
    logic r, ve, v; logic [1:0] om; logic [19:0] mx, se, sf, sa;
    run_txn(2'b00, 20'h80000, 20'h78000, 20'h00000, 1'b0, r, ve, v, om, mx, se, sf, sa);
    checks++;
    if (v !== 1'b1 || mx !== 20'h78000) begin
      errors++; $display("FAIL sat_max: vld=%b got %h, required 1 78000", v, mx);
    end
    checks++;
    if (se !== 20'h78000 || sf !== 20'h00000 || sa !== 20'h78000) begin
      errors++;
      $display("FAIL sat_shifts: got %h %h %h, required 78000 00000 78000", se, sf, sa);
    end
  endtask

  task automatic test_mode01_acc_zero;
    logic r, ve, v; logic [1:0] om; logic [19:0] mx, se, sf, sa;
    run_txn(2'b01, 20'h02B9C, 20'h053A6, 20'h7D1F4, 1'b1, r, ve, v, om, mx, se, sf, sa);
    checks++;
    if (v !== 1'b1 || mx !== 20'h053A6 || om !== 2'b01) begin
      errors++; $display("FAIL m01_max: vld=%b mode=%b got %h, required 1 01 053a6", v, om, mx);
    end
    checks++;
    if (se !== 20'h0280A || sf !== 20'h00000 || sa !== 20'h07C1F) begin
      errors++;
      $display("FAIL m01_shifts: got %h %h %h, required 0280a 00000 07c1f", se, sf, sa);
    end
  endtask

  task automatic test_mode10_11;
    logic r, ve, v; logic [1:0] om; logic [19:0] mx, se, sf, sa;
    logic [1:0] md;
    for (int k = 0; k < 2; k++) begin
      md = (k == 0) ? 2'b10 : 2'b11;
      run_txn(md, 20'hCF2C0, 20'hCF2CA, 20'hCF25C, 1'b0, r, ve, v, om, mx, se, sf, sa);
      checks++;
      if (v !== 1'b1 || mx !== 20'hCF2CA || om !== md) begin
        errors++;
        $display("FAIL m1x_max: vld=%b mode=%b got %h, required 1 %b cf2ca", v, om, mx, md);
      end
      checks++;
      if (se !== 20'h0000A || sf !== 20'h00000 || sa !== 20'h0003F) begin
        errors++;
        $display("FAIL m1x_shifts: mode %b got %h %h %h, required 0000a 00000 0003f",
                 md, se, sf, sa);
      end
    end
  endtask

  task automatic test_back_pressure;
    int sent, got, cyc;
    logic acc_now, con_now;
    @(posedge clk); #1;
    out_rdy = 1'b0; sent = 0; got = 0;
    in_vld = 1'b1; mode = 2'b00; exp_E = 20'd1; exp_F = 20'd0; exp_acc = 20'd0;
    acc_zero = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1) begin
        errors++; $display("FAIL bp_accept%0d: in_rdy=%b, required 1", k, in_rdy);
      end
      @(posedge clk); #1;
      sent++; exp_E = 20'(sent + 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b1 || max_exp !== 20'd1 || sh_F !== 20'd1) begin
        errors++;
        $display("FAIL bp_stall%0d: in_rdy=%b vld=%b max=%h shF=%h, required 0 1 00001 00001",
                 k, in_rdy, out_vld, max_exp, sh_F);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1; #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL bp_release_rdy: in_rdy=%b, required 1", in_rdy);
    end
    cyc = 0;
    while (got < 4 && cyc < 20) begin
      @(negedge clk);
      con_now = out_vld && out_rdy;
      acc_now = in_vld && in_rdy;
      if (con_now) begin
        checks++;
        if (max_exp !== 20'(got + 1) || sh_F !== 20'(got + 1) || sh_E !== 20'd0) begin
          errors++;
          $display("FAIL bp_order%0d: max=%h shF=%h shE=%h, required %h %h 00000",
                   got, max_exp, sh_F, sh_E, 20'(got + 1), 20'(got + 1));
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        sent++;
        if (sent < 4) exp_E = 20'(sent + 1);
        else in_vld = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (got != 4 || sent != 4) begin
      errors++; $display("FAIL bp_count: got=%0d sent=%0d, required 4 4", got, sent);
    end
    in_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0) begin
        errors++; $display("FAIL bp_no_dup%0d: out_vld=%b, required 0", k, out_vld);
      end
    end
  endtask

  task automatic test_reset_midflight;
    @(posedge clk); #1;
    out_rdy = 1'b0; in_vld = 1'b1; mode = 2'b01; exp_E = 20'h02B9C; exp_F = 20'h053A6;
    exp_acc = 20'h7D1F4; acc_zero = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b1 || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: out_vld=%b in_rdy=%b, required 1 0", out_vld, in_rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0 || out_mode !== 2'b00 || max_exp !== 20'd0 || sh_E !== 20'd0 ||
        sh_F !== 20'd0 || sh_acc !== 20'd0) begin
      errors++;
      $display("FAIL rst_mid: vld=%b mode=%b max=%h shE=%h shF=%h shA=%h, required all 0",
               out_vld, out_mode, max_exp, sh_E, sh_F, sh_acc);
    end
    @(negedge clk); rst_n = 1'b1; out_rdy = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_rdy: in_rdy=%b, required 1", in_rdy);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0) begin
        errors++; $display("FAIL rst_stale%0d: out_vld=%b, required 0", k, out_vld);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mode00_stream();
    test_mode00_saturation();
    test_mode01_acc_zero();
    test_mode10_11();
    test_back_pressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
